// File: rtl/alu_seq_if.sv
// alu_seq_if: issue/complete bundle between the controller and alu_seq.
//   start, opcode, a, b   : issue request and operands (controller -> ALU)
//   ready                 : ALU idle, an issue is accepted this edge
//   done                  : one-cycle pulse, result/flags just updated
//   result, flags         : registered result and {Z, C, O, L, N} status
interface alu_seq_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [3:0]       opcode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ready;
    logic             done;
    logic [WIDTH-1:0] result;
    logic [4:0]       flags;

    modport master (
        output start, opcode, a, b,
        input  ready, done, result, flags
    );

    modport slave (
        input  start, opcode, a, b,
        output ready, done, result, flags
    );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: sequential parametrised ALU with a persistent {Z,C,O,L,N} status
// register, an iterative one-bit-per-cycle shifter and a shift-add unsigned
// multiplier.
//   clk    : rising-edge clock
//   reset  : synchronous active-high reset, aborts any op in flight
//   bus    : alu_seq_if slave port (start/opcode/a/b in; ready/done/result/flags out)
module alu_seq #(
    parameter int WIDTH = 16
) (
    input  logic     clk,
    input  logic     reset,
    alu_seq_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [3:0] OP_NOP  = 4'b0000;
    localparam logic [3:0] OP_AND  = 4'b0001;
    localparam logic [3:0] OP_OR   = 4'b0010;
    localparam logic [3:0] OP_XOR  = 4'b0011;
    localparam logic [3:0] OP_LSH  = 4'b0100;
    localparam logic [3:0] OP_ADD  = 4'b0101;
    localparam logic [3:0] OP_ADDU = 4'b0110;
    localparam logic [3:0] OP_ADDC = 4'b0111;
    localparam logic [3:0] OP_NOT  = 4'b1000;
    localparam logic [3:0] OP_SUB  = 4'b1001;
    localparam logic [3:0] OP_SUBC = 4'b1010;
    localparam logic [3:0] OP_CMP  = 4'b1011;
    localparam logic [3:0] OP_ASHU = 4'b1100;
    localparam logic [3:0] OP_MUL  = 4'b1110;

    // Flag bit positions within the status register
    localparam int FZ = 4;
    localparam int FC = 3;
    localparam int FO = 2;
    localparam int FL = 1;
    localparam int FN = 0;

    typedef enum logic [1:0] {IDLE, SHIFT, MUL} state_t;

    state_t             state, state_next;
    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   sh_val;
    logic               sh_right;
    logic               sh_arith;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [WIDTH-1:0]   result_q;
    logic [4:0]         flags_q;
    logic               done_q;

    logic               cin;
    logic [WIDTH:0]     sum_ext;
    logic [WIDTH:0]     diff_ext;
    logic               add_ovf;
    logic               sub_ovf;
    logic [WIDTH:0]     b_ext;
    logic [WIDTH:0]     b_mag;
    logic [CW-1:0]      n_shift;
    logic [WIDTH-1:0]   sh_step;
    logic [2*WIDTH-1:0] acc_step;
    logic               last_iter;

    assign bus.result = result_q;
    assign bus.flags  = flags_q;
    assign bus.done   = done_q;

    // Operand arithmetic for the single-cycle ops
    always_comb begin
        cin      = ((bus.opcode == OP_ADDC) || (bus.opcode == OP_SUBC)) & flags_q[FC];
        sum_ext  = {1'b0, bus.a} + {1'b0, bus.b} + (WIDTH+1)'(cin);
        // Bit WIDTH of the extended difference is set exactly when a < b + cin
        diff_ext = {1'b0, bus.a} - {1'b0, bus.b} - (WIDTH+1)'(cin);
        add_ovf  = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum_ext[WIDTH-1] != bus.a[WIDTH-1]);
        sub_ovf  = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (diff_ext[WIDTH-1] != bus.a[WIDTH-1]);
    end

    // Shift count: |b| in WIDTH+1 bits so the most-negative b does not wrap
    always_comb begin
        b_ext = {bus.b[WIDTH-1], bus.b};
        b_mag = bus.b[WIDTH-1] ? -b_ext : b_ext;
        if (b_mag > (WIDTH+1)'(WIDTH)) begin
            n_shift = CW'(WIDTH);
        end else begin
            n_shift = b_mag[CW-1:0];
        end
    end

    // One iteration of the shifter and the multiplier
    always_comb begin
        if (sh_right) begin
            sh_step = {sh_arith & sh_val[WIDTH-1], sh_val[WIDTH-1:1]};
        end else begin
            sh_step = {sh_val[WIDTH-2:0], 1'b0};
        end
        acc_step  = acc + (mplier[0] ? mcand : '0);
        last_iter = (cnt == CW'(1));
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    if (((bus.opcode == OP_LSH) || (bus.opcode == OP_ASHU)) && (n_shift != '0)) begin
                        state_next = SHIFT;
                    end else if (bus.opcode == OP_MUL) begin
                        state_next = MUL;
                    end
                end
            end
            SHIFT, MUL: begin
                if (last_iter) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        bus.ready = (state == IDLE);
    end

    // Datapath, result/status registers and done pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            result_q <= '0;
            flags_q  <= '0;
            done_q   <= 1'b0;
            cnt      <= '0;
            sh_val   <= '0;
            sh_right <= 1'b0;
            sh_arith <= 1'b0;
            acc      <= '0;
            mcand    <= '0;
            mplier   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        case (bus.opcode)
                            OP_ADD, OP_ADDC: begin
                                result_q    <= sum_ext[WIDTH-1:0];
                                flags_q[FC] <= sum_ext[WIDTH];
                                flags_q[FO] <= add_ovf;
                                done_q      <= 1'b1;
                            end
                            OP_ADDU: begin
                                result_q <= sum_ext[WIDTH-1:0];
                                done_q   <= 1'b1;
                            end
                            OP_SUB, OP_SUBC: begin
                                result_q    <= diff_ext[WIDTH-1:0];
                                flags_q[FC] <= diff_ext[WIDTH];
                                flags_q[FO] <= sub_ovf;
                                done_q      <= 1'b1;
                            end
                            OP_CMP: begin
                                flags_q[FZ] <= (bus.a == bus.b);
                                flags_q[FL] <= (bus.a < bus.b);
                                flags_q[FN] <= ($signed(bus.a) < $signed(bus.b));
                                done_q      <= 1'b1;
                            end
                            OP_AND: begin
                                result_q <= bus.a & bus.b;
                                done_q   <= 1'b1;
                            end
                            OP_OR: begin
                                result_q <= bus.a | bus.b;
                                done_q   <= 1'b1;
                            end
                            OP_XOR: begin
                                result_q <= bus.a ^ bus.b;
                                done_q   <= 1'b1;
                            end
                            OP_NOT: begin
                                result_q <= ~bus.a;
                                done_q   <= 1'b1;
                            end
                            OP_LSH, OP_ASHU: begin
                                if (n_shift == '0) begin
                                    result_q <= bus.a;
                                    done_q   <= 1'b1;
                                end else begin
                                    sh_val   <= bus.a;
                                    cnt      <= n_shift;
                                    sh_right <= bus.b[WIDTH-1];
                                    sh_arith <= (bus.opcode == OP_ASHU);
                                end
                            end
                            OP_MUL: begin
                                acc    <= '0;
                                mcand  <= {{WIDTH{1'b0}}, bus.a};
                                mplier <= bus.b;
                                cnt    <= CW'(WIDTH);
                            end
                            default: done_q <= 1'b1;
                        endcase
                    end
                end
                SHIFT: begin
                    sh_val <= sh_step;
                    cnt    <= cnt - CW'(1);
                    if (last_iter) begin
                        result_q <= sh_step;
                        done_q   <= 1'b1;
                    end
                end
                MUL: begin
                    acc    <= acc_step;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt - CW'(1);
                    // Final partial product is folded in on the same edge that publishes
                    if (last_iter) begin
                        result_q    <= acc_step[WIDTH-1:0];
                        flags_q[FC] <= |acc_step[2*WIDTH-1:WIDTH];
                        done_q      <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
